// File: rtl/ysyx_22050243_pipe_ctrl.sv
// ysyx_22050243_pipe_ctrl: hazard/flow controller driving the PC and the four pipeline slices.
// Latency: all slice commands are combinational from state, valid bits and inputs; valid bits and FSM update each clk.
// Backpressure: mem_busy freezes everything up to EX/MEM, ex_busy freezes up to ID/EX, fetch misses bubble IF/ID.
// Optional macro YSYX_22050243_PIPE_PERF_EN adds stall_cycles/flush_events perf counters.
module ysyx_22050243_pipe_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_ready,
  input  logic                  mem_busy,
  input  logic                  ex_busy,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_wen,
  input  logic                  ex_is_load,
  input  logic                  ex_redirect,
  input  logic                  mem_trap,
  output logic                  pc_stall,
  output logic                  pc_sel_redirect,
  output logic                  pc_sel_trap,
  output logic                  ifid_en,
  output logic                  ifid_stall,
  output logic                  ifid_flush,
  output logic                  idex_en,
  output logic                  idex_stall,
  output logic                  idex_flush,
  output logic                  exmem_en,
  output logic                  exmem_stall,
  output logic                  exmem_flush,
  output logic                  memwb_en,
  output logic                  memwb_stall,
  output logic                  memwb_flush
`ifdef YSYX_22050243_PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
`endif
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   v_id_q, v_ex_q, v_mem_q, v_wb_q;
  logic   v_id_d, v_ex_d, v_mem_d, v_wb_d;
  logic   load_use;
  logic   trap_take;

  // Mirror of a slice register: flush beats stall beats enable; en=0 loads a bubble.
  function automatic logic slice_next(input logic flush, input logic stall,
                                      input logic en, input logic cur, input logic up);
    if (flush)      slice_next = 1'b0;
    else if (stall) slice_next = cur;
    else if (en)    slice_next = up;
    else            slice_next = 1'b0;
  endfunction

  // Load-use hazard: a valid load in EX writes a register the valid ID instruction reads; x0 never hazards.
  always_comb begin
    load_use = v_ex_q & ex_is_load & ex_wen & (ex_rd != '0) & v_id_q &
               ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
    trap_take = mem_trap & v_mem_q;
  end

  // Next-state and per-slice command selection; rules are checked in priority order.
  always_comb begin
    state_d         = state_q;
    pc_stall        = 1'b0;
    pc_sel_redirect = 1'b0;
    pc_sel_trap     = 1'b0;
    ifid_en  = 1'b0; ifid_stall  = 1'b0; ifid_flush  = 1'b0;
    idex_en  = 1'b0; idex_stall  = 1'b0; idex_flush  = 1'b0;
    exmem_en = 1'b0; exmem_stall = 1'b0; exmem_flush = 1'b0;
    memwb_en = 1'b0; memwb_stall = 1'b0; memwb_flush = 1'b0;
    if (rst) begin
      pc_stall    = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
      state_d     = S_RUN;
    end else begin
      case (state_q)
        S_RUN: begin
          if (mem_busy || trap_take) begin
            // Memory hold; a committing trap also freezes the pipe so nothing younger retires.
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            if (trap_take) state_d = mem_busy ? S_DRAIN : S_FLUSH;
          end else if (ex_busy) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_stall = 1'b1;
            memwb_en   = 1'b1;
          end else if (ex_redirect && v_ex_q) begin
            pc_sel_redirect = 1'b1;
            ifid_flush      = 1'b1;
            idex_flush      = 1'b1;
            exmem_en        = 1'b1;
            memwb_en        = 1'b1;
          end else if (load_use) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
          end else if (!if_ready) begin
            pc_stall = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
          end else begin
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
          end
        end
        S_DRAIN: begin
          // Wait for the outstanding memory access; the exit cycle still holds.
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_stall  = 1'b1;
          exmem_stall = 1'b1;
          if (!mem_busy) state_d = S_FLUSH;
        end
        S_FLUSH: begin
          pc_sel_trap = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          memwb_flush = 1'b1;
          state_d     = S_RUN;
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  // Valid bits follow the slices they shadow.
  always_comb begin
    v_id_d  = slice_next(ifid_flush,  ifid_stall,  ifid_en,  v_id_q,  if_ready);
    v_ex_d  = slice_next(idex_flush,  idex_stall,  idex_en,  v_ex_q,  v_id_q);
    v_mem_d = slice_next(exmem_flush, exmem_stall, exmem_en, v_mem_q, v_ex_q);
    v_wb_d  = slice_next(memwb_flush, memwb_stall, memwb_en, v_wb_q,  v_mem_q);
  end

  // State and valid-bit registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      v_id_q  <= 1'b0;
      v_ex_q  <= 1'b0;
      v_mem_q <= 1'b0;
      v_wb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      v_id_q  <= v_id_d;
      v_ex_q  <= v_ex_d;
      v_mem_q <= v_mem_d;
      v_wb_q  <= v_wb_d;
    end
  end

`ifdef YSYX_22050243_PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;

  // Counters wrap naturally at 2^CNT_W.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (!rst && pc_stall)                      stall_cycles_d = stall_cycles_q + 1'b1;
    if (!rst && (pc_sel_redirect || pc_sel_trap)) flush_events_d = flush_events_q + 1'b1;
  end

  // Perf counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_ysyx_22050243_pipe_ctrl.sv
// Directed bench for ysyx_22050243_pipe_ctrl: hazards, redirects, traps, drain and reset.
module tb_ysyx_22050243_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       if_ready, mem_busy, ex_busy;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_rs1_used, id_rs2_used, ex_wen, ex_is_load, ex_redirect, mem_trap;
  logic       pc_stall, pc_sel_redirect, pc_sel_trap;
  logic       ifid_en, ifid_stall, ifid_flush;
  logic       idex_en, idex_stall, idex_flush;
  logic       exmem_en, exmem_stall, exmem_flush;
  logic       memwb_en, memwb_stall, memwb_flush;
`ifdef YSYX_22050243_PIPE_PERF_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  ysyx_22050243_pipe_ctrl dut (
    .clk(clk), .rst(rst), .if_ready(if_ready), .mem_busy(mem_busy), .ex_busy(ex_busy),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .mem_trap(mem_trap), .pc_stall(pc_stall), .pc_sel_redirect(pc_sel_redirect),
    .pc_sel_trap(pc_sel_trap),
    .ifid_en(ifid_en), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_stall(idex_stall), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .exmem_stall(exmem_stall), .exmem_flush(exmem_flush),
    .memwb_en(memwb_en), .memwb_stall(memwb_stall), .memwb_flush(memwb_flush)
`ifdef YSYX_22050243_PIPE_PERF_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  // {pc_stall, sel_redirect, sel_trap, ifid{en,stall,flush}, idex{..}, exmem{..}, memwb{..}}
  logic [14:0] ctl;
  assign ctl = {pc_stall, pc_sel_redirect, pc_sel_trap,
                ifid_en, ifid_stall, ifid_flush, idex_en, idex_stall, idex_flush,
                exmem_en, exmem_stall, exmem_flush, memwb_en, memwb_stall, memwb_flush};

  localparam logic [14:0] C_ALL_EN = 15'b000_100_100_100_100;
  localparam logic [14:0] C_RST    = 15'b100_001_001_001_001;
  localparam logic [14:0] C_LU     = 15'b100_010_000_100_100;
  localparam logic [14:0] C_IFNR   = 15'b100_000_100_100_100;
  localparam logic [14:0] C_RED    = 15'b010_001_001_100_100;
  localparam logic [14:0] C_MEMB   = 15'b100_010_010_010_000;
  localparam logic [14:0] C_EXB    = 15'b100_010_010_000_100;
  localparam logic [14:0] C_FLUSH  = 15'b001_001_001_001_001;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Check the combinational command mid-cycle, then advance one clock.
  task automatic step(input string tag, input logic [14:0] exp);
    #2;
    check(tag, {17'd0, ctl}, {17'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rst = 1'b0; if_ready = 1'b1; mem_busy = 1'b0; ex_busy = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_rd = '0; ex_wen = 1'b0; ex_is_load = 1'b0; ex_redirect = 1'b0; mem_trap = 1'b0;
  endtask

  // Run clean cycles so every stage holds a valid instruction.
  task automatic fill();
    clr();
    for (int i = 0; i < 4; i++) step("fill", C_ALL_EN);
  endtask

  task automatic set_load_x5_use();
    ex_is_load = 1'b1; ex_wen = 1'b1; ex_rd = 5'd5;
    id_rs1 = 5'd5; id_rs1_used = 1'b1;
  endtask

  initial begin
    clr();
    rst = 1'b1;
    #1;
    step("reset0", C_RST);
    step("reset1", C_RST);

    // Load-use: one stall cycle, then the bubble clears the hazard.
    fill();
    set_load_x5_use();
    step("load_use", C_LU);
    step("load_use_after", C_ALL_EN);

    // Load into x0 with ID reading x0: no hazard.
    clr();
    ex_is_load = 1'b1; ex_wen = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1;
    step("load_x0", C_ALL_EN);

    // Redirect beats load-use and a fetch miss.
    clr();
    set_load_x5_use();
    if_ready = 1'b0; ex_redirect = 1'b1;
    step("redirect", C_RED);
    // EX and ID were flushed, so the same inputs now only show the fetch miss.
    step("redirect_gone", C_IFNR);

    // Trap with a busy memory: hold through drain and exit, then one flush cycle.
    fill();
    mem_trap = 1'b1; mem_busy = 1'b1; ex_redirect = 1'b1;
    step("trap_busy0", C_MEMB);
    mem_trap = 1'b0;
    step("drain1", C_MEMB);
    step("drain2", C_MEMB);
    mem_busy = 1'b0;
    step("drain_exit", C_MEMB);
    step("trap_flush", C_FLUSH);
    // Back in RUN with valid bits clear: redirect ignored, fetch miss stalls PC.
    if_ready = 1'b0; ex_redirect = 1'b1;
    step("post_trap", C_IFNR);

    // Trap and redirect together without memory busy: no redirect, then flush.
    fill();
    mem_trap = 1'b1; ex_redirect = 1'b1;
    #2;
    check("trap_no_redirect", {31'd0, pc_sel_redirect}, 32'd0);
    @(posedge clk); #1;
    clr();
    step("trap_flush2", C_FLUSH);

    // Multicycle EX while fetch is idle.
    fill();
    ex_busy = 1'b1; if_ready = 1'b0;
    for (int i = 0; i < 4; i++) step("ex_busy", C_EXB);
    clr();
    step("ex_busy_done", C_ALL_EN);

    // Reset in the middle of a drain abandons the trap.
    fill();
    mem_trap = 1'b1; mem_busy = 1'b1;
    step("drain_enter", C_MEMB);
    rst = 1'b1;
    step("rst_in_drain", C_RST);
    clr();
`ifdef YSYX_22050243_PIPE_PERF_EN
    #2;
    check("stall_cnt_rst", stall_cycles, 32'd0);
    check("flush_cnt_rst", flush_events, 32'd0);
    #-2;
`endif
    step("after_rst", C_ALL_EN);
    step("after_rst2", C_ALL_EN);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_22050243_pipe_ctrl.md
Name: ysyx_22050243_pipe_ctrl

Overview:
- Central hazard and flow controller that drives the `en`/`stall`/`flush` inputs of every pipeline register slice in the 5-stage core (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register.
- Tracks per-stage valid bits and detects load-use hazards.
- Sequences branch redirects and traps through a small FSM, so each slice sees exactly one coherent command per cycle.

Parameters:
- REG_ADDR_W, 5, register-index width.
- CNT_W, 32, perf counter width (used only with the optional feature).

Ports:
- clk in 1 core clock
- rst in 1 synchronous active-high reset
- if_ready in 1 fetch returned an instruction this cycle
- mem_busy in 1 data-memory access in MEM not yet complete
- ex_busy in 1 multicycle unit in EX not done
- id_rs1 in REG_ADDR_W source 1 of the ID instruction
- id_rs2 in REG_ADDR_W source 2 of the ID instruction
- id_rs1_used in 1 ID instruction reads rs1
- id_rs2_used in 1 ID instruction reads rs2
- ex_rd in REG_ADDR_W destination of the EX instruction
- ex_wen in 1 EX instruction writes rd
- ex_is_load in 1 EX instruction is a load
- ex_redirect in 1 taken branch/jump resolved in EX
- mem_trap in 1 exception/ecall/mret committing in MEM
- pc_stall out 1 hold PC
- pc_sel_redirect out 1 PC takes branch target this cycle
- pc_sel_trap out 1 PC takes trap vector this cycle
- ifid_en, ifid_stall, ifid_flush out 1 each, IF/ID slice control
- idex_en, idex_stall, idex_flush out 1 each, ID/EX slice control
- exmem_en, exmem_stall, exmem_flush out 1 each, EX/MEM slice control
- memwb_en, memwb_stall, memwb_flush out 1 each, MEM/WB slice control

Behaviour:
- Slice semantics:
  - Priority is flush > stall > en.
  - en=0 with no stall or flush loads a bubble (zero).
  - All outputs are combinational from FSM state, valid bits and inputs.
- Valid bits v_id, v_ex, v_mem, v_wb:
  - Registered; updated exactly as the slices would be.
  - Loaded with the upstream valid on en, held on stall, cleared on flush or bubble.
  - Upstream valid of IF is if_ready.
- load_use = v_ex & ex_is_load & ex_wen & (ex_rd!=0) & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)) & v_id.
- RUN state, first matching rule wins:
  1. mem_busy: pc/ifid/idex/exmem stall=1; memwb en=0 (bubble).
  2. ex_busy: pc/ifid/idex stall=1; exmem bubble; memwb en=1.
  3. ex_redirect & v_ex: ifid_flush=1, idex_flush=1; pc_sel_redirect=1; exmem/memwb en=1. Overrides load_use and !if_ready.
  4. load_use: pc/ifid stall=1; idex bubble; exmem/memwb en=1.
  5. !if_ready: pc_stall=1; ifid bubble; others en=1.
  6. Otherwise: all en=1, stall=0, flush=0.
- Trap handling:
  - mem_trap & v_mem in RUN takes precedence over rules 2–6: go to DRAIN if mem_busy, else FLUSH.
- DRAIN state:
  - Identical to rule 1 every cycle.
  - Leave to FLUSH on the first cycle mem_busy=0; that cycle still applies rule 1.
- FLUSH state (exactly one cycle):
  - All four *_flush=1, pc_sel_trap=1, pc_stall=0.
  - All valid bits cleared; next state RUN.
- pc_sel_redirect and pc_sel_trap are never both 1.
- ex_redirect and mem_trap in the same cycle: trap wins, because the branch is younger.
- Reset:
  - While rst=1: all *_flush=1, all en/stall=0, pc_stall=1, pc_sel_*=0.
  - State returns to RUN; valid bits cleared.
  - Reset mid-DRAIN abandons the trap.
- ex_rd==0 never creates a hazard. A load into x0 proceeds without a bubble.
- No combinational path from any *_stall output back into this block's inputs is assumed.

Optional Feature:
- Macro: YSYX_22050243_PIPE_PERF_EN.
- When defined, adds outputs stall_cycles [CNT_W] and flush_events [CNT_W]:
  - stall_cycles: +1 on every cycle with pc_stall=1 and rst=0.
  - flush_events: +1 on each redirect or FLUSH-state cycle.
  - Both zero on rst and wrap at 2^CNT_W.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load x5 in EX (v_ex=1, ex_is_load=1, ex_wen=1), ID reads rs1=5 -> 1 cycle with pc_stall=ifid_stall=1 and idex_en=0; next cycle all en=1.
- Load to x0 in EX, ID rs1=0 -> no stall; all en=1.
- ex_redirect=1 & v_ex together with load_use=1 -> ifid_flush=idex_flush=1, pc_sel_redirect=1, pc_stall=0.
- mem_trap=1 with mem_busy=1 for 3 cycles -> 3 DRAIN cycles plus exit cycle (memwb_en=0, others stalled); then 1 cycle with all flush=1 and pc_sel_trap=1; valid bits 0; RUN.
- ex_busy=1 for 4 cycles while if_ready=0 -> pc/ifid/idex stall and exmem bubble each cycle; ifid not bubbled while stalled.
- rst asserted during DRAIN -> same-cycle all flush=1 and pc_stall=1; after release, RUN with no pc_sel_trap; perf counters (if enabled) read 0.
